program_reload_seq: RTL and testbench
=====================================

# program_reload_seq

Sequencer that owns the core-reset and program-load-enable controls of the Briey RISC-V simulation/FPGA wrapper. It releases the core after power-on and, on request, performs a full image reload: it holds the core in reset, enables the program loader, counts accepted AW and W beats until the whole image is written, then releases the core. It sits between the testbench or host control and the `Briey_Wrap` `axi4_mm_rst_n` / `program_load_en` inputs. It replaces the fixed-delay reset/load stimulus with a handshake-checked sequence that has a timeout.

## Interface
Parameters:
- IMAGE_BYTES, 2048, program image size in bytes.
- BEAT_BYTES, 64, bytes per loader beat (512-bit data); NUM_BEATS = IMAGE_BYTES/BEAT_BYTES = 32.
- INIT_CYCLES, 25, core-reset hold after `rst` deasserts.
- PRE_CYCLES, 25, core-reset hold before `load_en` asserts.
- POST_CYCLES, 20, core-reset hold after the load completes.
- TIMEOUT, 1024, maximum cycles allowed in LOAD.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- reload_req  in  1  single-cycle request to reload and restart.
- aw_valid, aw_ready  in  1 each  monitored loader AW handshake.
- w_valid, w_ready  in  1 each  monitored loader W handshake.
- core_rst  out  1  core/RAM reset, active-high (wrapper sees `!core_rst`).
- load_en  out  1  program_load_en to the loader and wrapper.
- busy  out  1  high in every state except RUN.
- done  out  1  one-cycle pulse on the LOAD→POST transition.
- error  out  1  sticky; high while in ERROR.
- beats  out  $clog2(NUM_BEATS+1)  number of W beats accepted in the current load.

## Operation
- States: INIT, RUN, PRE, LOAD, POST, ERROR.
- Outputs decoded from registered state:
  - core_rst = 1 in all states except RUN.
  - load_en = 1 only in LOAD.
- **INIT:** count INIT_CYCLES, then go to RUN.
- **RUN:** reload_req → PRE.
- **PRE:** count PRE_CYCLES, then go to LOAD. Clear the aw/w beat counts and the timeout count on entry.
- **LOAD:**
  - aw_fire = aw_valid & aw_ready; w_fire = w_valid & w_ready. Each increments its own counter.
  - Counters saturate at NUM_BEATS.
  - Fires outside LOAD are ignored.
  - When both counts equal NUM_BEATS, including a fire in the current cycle, go to POST and pulse done.
  - Otherwise, when the timeout count reaches TIMEOUT-1, go to ERROR.
  - If completion and timeout occur in the same cycle, completion wins.
- **POST:** count POST_CYCLES, then go to RUN.
- **ERROR:** core_rst=1, load_en=0, error=1. reload_req → PRE, and error clears on that transition.
- reload_req in INIT, PRE, LOAD or POST is ignored and not queued.
- All phase counters are zeroed on each state entry.

## Timing
- During reset: state=INIT, core_rst=1, load_en=0, busy=1, done=0, error=0, beats=0.
- INIT: rst deasserts at edge 0; core_rst falls at edge INIT_CYCLES.
- Reload: reload_req sampled at edge N.
  - core_rst=1 from edge N+1.
  - load_en=1 from edge N+1+PRE_CYCLES.
- load_en falls one cycle after the completing handshake.
  - With ready always high and valid from the loader, load_en is high for exactly NUM_BEATS cycles.
- POST: core_rst falls POST_CYCLES after the load ends.
- done and error update on the same edge as their state transition.
- rst during any state: INIT at the next edge and load_en=0. No partial-load state is retained.

## Structure
- Package `reload_seq_pkg`:
  - state enum `reload_state_e`.
  - default constants for the loader geometry (2048 B, 64 B beats, 15-bit address).
  - derived NUM_BEATS.
- Sub-module `beat_counter`, instantiated twice (AW, W):
  - inputs: clear, fire, enable.
  - behaviour: saturating count, `full` flag at NUM_BEATS.

## Test plan
- Power-on: rst high 25 cycles, then low → core_rst=1 for exactly 25 cycles, then 0; busy follows; load_en stays 0.
- Clean reload: reload_req in RUN, loader always ready → load_en high 25 cycles later for 32 cycles; beats=32; done pulses once; core_rst falls 20 cycles after load_en falls.
- Backpressure: w_ready toggles 1/0 and aw_ready lags by 3 cycles → LOAD lasts until the 32nd W fire; the extra aw_valid after aw_cnt=32 is not counted; done fires once.
- Timeout: w_ready held 0 in LOAD → ERROR after 1024 cycles, error=1, load_en=0, core_rst=1. A subsequent reload_req clears error and completes a normal load.
- Ignored request plus mid-load reset: reload_req at beat 10 has no effect. rst at beat 20 → load_en=0 and core_rst=1 next edge, state=INIT, beats=0.

Source files
------------

// File: rtl/reload_seq_pkg.sv
// reload_seq_pkg: shared states and loader geometry for the program reload sequencer.
package reload_seq_pkg;
    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_RUN   = 3'd1,
        S_PRE   = 3'd2,
        S_LOAD  = 3'd3,
        S_POST  = 3'd4,
        S_ERROR = 3'd5
    } reload_state_e;
    localparam int IMAGE_BYTES_DEF = 2048;
    localparam int BEAT_BYTES_DEF  = 64;
    localparam int ADDR_W          = 15;
    localparam int NUM_BEATS_DEF   = IMAGE_BYTES_DEF / BEAT_BYTES_DEF;
endpackage

// File: rtl/beat_counter.sv
// beat_counter: saturating count of accepted loader beats; adv marks a beat taken this cycle.
module beat_counter #(
    parameter int NUM_BEATS = 32,
    parameter int CW        = $clog2(NUM_BEATS + 1)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          fire,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          adv
);
    logic full;
    assign full = count == CW'(NUM_BEATS);
    assign adv  = enable & fire & ~full;
    always_ff @(posedge clk)
        count <= clear ? '0 : count + CW'(adv);
endmodule

// File: rtl/program_reload_seq.sv
// program_reload_seq: holds the core in reset, runs a beat-counted image reload with timeout, then releases it.
module program_reload_seq
    import reload_seq_pkg::*;
#(
    parameter int IMAGE_BYTES = IMAGE_BYTES_DEF,
    parameter int BEAT_BYTES  = BEAT_BYTES_DEF,
    parameter int INIT_CYCLES = 25,
    parameter int PRE_CYCLES  = 25,
    parameter int POST_CYCLES = 20,
    parameter int TIMEOUT     = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic reload_req,
    input  logic aw_valid,
    input  logic aw_ready,
    input  logic w_valid,
    input  logic w_ready,
    output logic core_rst,
    output logic load_en,
    output logic busy,
    output logic done,
    output logic error,
    output logic [$clog2(IMAGE_BYTES/BEAT_BYTES+1)-1:0] beats
);
    localparam int NUM_BEATS = IMAGE_BYTES / BEAT_BYTES;
    localparam int CW        = $clog2(NUM_BEATS + 1);
    localparam int TW        = 16;
    reload_state_e state, nxt;
    logic [TW-1:0] cnt;
    logic [CW-1:0] aw_cnt, w_cnt;
    logic          aw_adv, w_adv, clr, in_load, complete;
    assign in_load  = state == S_LOAD;
    assign clr      = rst | (state == S_PRE);
    assign core_rst = state != S_RUN;
    assign busy     = core_rst;
    assign load_en  = in_load;
    assign beats    = w_cnt;
    beat_counter #(.NUM_BEATS(NUM_BEATS)) u_aw (
        .clk(clk), .clear(clr), .fire(aw_valid & aw_ready), .enable(in_load),
        .count(aw_cnt), .adv(aw_adv)
    );
    beat_counter #(.NUM_BEATS(NUM_BEATS)) u_w (
        .clk(clk), .clear(clr), .fire(w_valid & w_ready), .enable(in_load),
        .count(w_cnt), .adv(w_adv)
    );
    // Completion looks at the counts after this cycle's beats so the last handshake ends LOAD immediately.
    assign complete = (aw_cnt + CW'(aw_adv) == CW'(NUM_BEATS)) & (w_cnt + CW'(w_adv) == CW'(NUM_BEATS));
    always_comb begin
        nxt = state;
        case (state)
            S_INIT:  nxt = cnt == TW'(INIT_CYCLES - 1) ? S_RUN : S_INIT;
            S_RUN:   nxt = reload_req ? S_PRE : S_RUN;
            S_PRE:   nxt = cnt == TW'(PRE_CYCLES - 1) ? S_LOAD : S_PRE;
            S_LOAD:  nxt = complete ? S_POST : cnt == TW'(TIMEOUT - 1) ? S_ERROR : S_LOAD;
            S_POST:  nxt = cnt == TW'(POST_CYCLES - 1) ? S_RUN : S_POST;
            S_ERROR: nxt = reload_req ? S_PRE : S_ERROR;
            default: nxt = S_INIT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            cnt   <= '0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= nxt != state ? '0 : cnt + 1'b1;
            done  <= in_load && nxt == S_POST;
            error <= nxt == S_ERROR;
        end
    end
endmodule

// File: tb/tb_program_reload_seq.sv
// tb_program_reload_seq: scoreboard of expected output edges (signal, value, cycle) checked by a negedge monitor.
module tb_program_reload_seq;
    typedef struct {
        int s;
        int v;
        int c;
    } evt_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reload_req = 1'b0;
    logic       aw_valid = 1'b1, aw_ready = 1'b1, w_valid = 1'b1, w_ready = 1'b1;
    logic       core_rst, load_en, busy, done, error;
    logic [5:0] beats;
    int         cyc = 0;
    int         tests = 0, fails = 0;
    int         mode = 0;
    int         ph = 0;
    bit         armed = 1'b0;
    evt_t       q[$];
    string      names[4] = '{"core_rst", "load_en", "done", "error"};

    program_reload_seq dut (
        .clk(clk), .rst(rst), .reload_req(reload_req),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .w_valid(w_valid), .w_ready(w_ready),
        .core_rst(core_rst), .load_en(load_en), .busy(busy), .done(done), .error(error),
        .beats(beats)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic expect_evt(input int s, input int v, input int c);
        evt_t e;
        e.s = s;
        e.v = v;
        e.c = c;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_reload();
        reload_req = 1'b1;
        @(negedge clk);
        reload_req = 1'b0;
    endtask

    // Loader readiness: 0 = always ready, 1 = W toggling with AW three cycles behind, 2 = W stalled.
    initial begin
        logic [3:0] wh;
        logic       w;
        wh = 4'hF;
        forever begin
            @(negedge clk);
            w = mode == 1 ? ((cyc % 2) != ph) : mode == 2 ? 1'b0 : 1'b1;
            wh = {wh[2:0], w};
            w_ready = w;
            aw_ready = mode == 1 ? wh[3] : 1'b1;
        end
    end

    initial begin
        logic [3:0] prev, cur;
        evt_t       e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {error, done, load_en, core_rst};
            if (armed) begin
                for (int s = 0; s < 4; s++) begin
                    if (cur[s] != prev[s]) begin
                        if (q.size() == 0) begin
                            check({"unexpected_", names[s]}, cyc, -1);
                        end else begin
                            e = q.pop_front();
                            check({names[s], "_edge_sig"}, s * 2 + int'(cur[s]), e.s * 2 + e.v);
                            check({names[s], "_edge_cyc"}, cyc, e.c);
                        end
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_core_rst", core_rst, 1);
        check("rst_load_en", load_en, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_beats", beats, 0);
        armed = 1'b1;
        wait_cyc(25);
        expect_evt(0, 0, cyc + 25);
        rst = 1'b0;
        wait_cyc(cyc + 30);
        check("run_busy", busy, 0);
        check("run_load_en", load_en, 0);

        // Clean reload with a loader that is always ready.
        n = cyc + 1;
        expect_evt(0, 1, n);
        expect_evt(1, 1, n + 25);
        expect_evt(1, 0, n + 57);
        expect_evt(2, 1, n + 57);
        expect_evt(2, 0, n + 58);
        expect_evt(0, 0, n + 77);
        pulse_reload();
        wait_cyc(n + 80);
        check("clean_beats", beats, 32);
        check("clean_busy", busy, 0);

        // Backpressure: W fires on odd LOAD cycles, AW on even ones.
        n = cyc + 1;
        ph = (n + 25) % 2;
        mode = 1;
        expect_evt(0, 1, n);
        expect_evt(1, 1, n + 25);
        expect_evt(1, 0, n + 89);
        expect_evt(2, 1, n + 89);
        expect_evt(2, 0, n + 90);
        expect_evt(0, 0, n + 109);
        pulse_reload();
        wait_cyc(n + 112);
        check("bp_beats", beats, 32);

        // Timeout with W stalled, then recovery from ERROR.
        n = cyc + 1;
        mode = 2;
        expect_evt(0, 1, n);
        expect_evt(1, 1, n + 25);
        expect_evt(1, 0, n + 1049);
        expect_evt(3, 1, n + 1049);
        pulse_reload();
        wait_cyc(n + 1052);
        check("to_error", error, 1);
        check("to_load_en", load_en, 0);
        check("to_core_rst", core_rst, 1);
        check("to_beats", beats, 0);
        mode = 0;
        n = cyc + 1;
        expect_evt(3, 0, n);
        expect_evt(1, 1, n + 25);
        expect_evt(1, 0, n + 57);
        expect_evt(2, 1, n + 57);
        expect_evt(2, 0, n + 58);
        expect_evt(0, 0, n + 77);
        pulse_reload();
        wait_cyc(n + 80);
        check("rec_beats", beats, 32);
        check("rec_error", error, 0);

        // Reload request mid-load is ignored; reset mid-load aborts everything.
        n = cyc + 1;
        expect_evt(0, 1, n);
        expect_evt(1, 1, n + 25);
        pulse_reload();
        wait_cyc(n + 35);
        check("mid_beats10", beats, 10);
        pulse_reload();
        wait_cyc(n + 45);
        check("mid_beats20", beats, 20);
        check("mid_load_en", load_en, 1);
        expect_evt(1, 0, n + 46);
        rst = 1'b1;
        @(negedge clk);
        check("abort_load_en", load_en, 0);
        check("abort_core_rst", core_rst, 1);
        check("abort_beats", beats, 0);
        check("abort_busy", busy, 1);
        expect_evt(0, 0, cyc + 25);
        rst = 1'b0;
        wait_cyc(cyc + 30);
        check("final_busy", busy, 0);
        check("pending_events", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
